// File: rtl/alu_pkg.sv
// Shared ALU definitions: default result width, source-unit IDs, buffered entry layout.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package alu_pkg;

    localparam int ALU_DATA_W = 16;

    localparam logic [1:0] UNIT_ARITH = 2'd0;
    localparam logic [1:0] UNIT_LOGIC = 2'd1;
    localparam logic [1:0] UNIT_CMP   = 2'd2;
    localparam logic [1:0] UNIT_SHIFT = 2'd3;

    // One buffered result at the default width: source tag above the raw data.
    typedef struct packed {
        logic [1:0]                   unit;
        logic signed [ALU_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/alu_result_fifo_if.sv
// Result stream from the collection FIFO to its consumer.
// Latency: none (wires only).
// Backpressure: consumer holds Res_ready low to keep the head entry presented.
interface alu_result_fifo_if
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
);
    logic                     Res_valid;
    logic                     Res_ready;
    logic signed [DATA_W-1:0] Res_data;
    logic [1:0]               Res_unit;

    modport master (output Res_valid, Res_data, Res_unit, input Res_ready);
    modport slave  (input Res_valid, Res_data, Res_unit, output Res_ready);
endinterface

// File: rtl/alu_sync_fifo.sv
// Generic synchronous FIFO, first-word-fall-through head, zero output when empty.
// Latency: a push is visible at the head one cycle later when the FIFO was empty.
// Backpressure: a push while full with no pop is dropped and flagged on drop.
module alu_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             drop
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Handshake decode and next-state for pointers, occupancy and storage.
    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        pop_vld  = (count_q != '0);
        do_pop   = pop_vld && pop_rdy;
        // A pop on the same edge frees a slot, so a full FIFO still accepts.
        do_push  = push_vld && (!full || do_pop);
        drop     = push_vld && full && !do_pop;
        pop_dat  = pop_vld ? mem_q[rd_ptr_q] : '0;
        count    = count_q;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards everything buffered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset; stale contents are never visible because count gates the head.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/alu_result_fifo.sv
// Collects ALU unit results by fixed priority, tags them with their source and buffers them.
// Latency: one cycle from a flag to Res_valid when the buffer was empty.
// Backpressure: Res_ready low holds the head; results arriving while full are dropped (sticky Overflow_err).
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] Arith_Out,
    input  logic                     Arith_Flag,
    input  logic signed [DATA_W-1:0] Logic_Out,
    input  logic                     Logic_Flag,
    input  logic signed [DATA_W-1:0] CMP_Out,
    input  logic                     CMP_Flag,
    input  logic signed [DATA_W-1:0] Shift_Out,
    input  logic                     Shift_Flag,
    input  logic                     Err_clr,
    alu_result_fifo_if.master        res,
    output logic [CNT_W-1:0]         Count,
    output logic                     Full,
    output logic                     Overflow_err,
    output logic                     Collision_err
);
    localparam int ENT_W = DATA_W + 2;

    logic [3:0]        flags;
    logic              sel_vld;
    logic [1:0]        sel_unit;
    logic [DATA_W-1:0] sel_dat;
    logic              multi_flag;
    logic              fifo_drop;
    logic [ENT_W-1:0]  head_dat;
    logic              overflow_q, overflow_d;
    logic              collision_q, collision_d;

    // Fixed-priority select Arith > Logic > CMP > Shift; losers of a collision are discarded.
    always_comb begin
        flags      = {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag};
        sel_vld    = (flags != 4'd0);
        // Clearing the lowest set bit leaves something only if two or more flags are set.
        multi_flag = ((flags & (flags - 4'd1)) != 4'd0);
        sel_unit   = UNIT_SHIFT;
        sel_dat    = Shift_Out;
        if (Arith_Flag) begin
            sel_unit = UNIT_ARITH;
            sel_dat  = Arith_Out;
        end else if (Logic_Flag) begin
            sel_unit = UNIT_LOGIC;
            sel_dat  = Logic_Out;
        end else if (CMP_Flag) begin
            sel_unit = UNIT_CMP;
            sel_dat  = CMP_Out;
        end
    end

    alu_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (sel_vld),
        .push_dat ({sel_unit, sel_dat}),
        .pop_rdy  (res.Res_ready),
        .pop_vld  (res.Res_valid),
        .pop_dat  (head_dat),
        .count    (Count),
        .full     (Full),
        .drop     (fifo_drop)
    );

    // Head entry is already zero when empty, so the split needs no extra gating.
    always_comb begin
        res.Res_unit = head_dat[ENT_W-1 -: 2];
        res.Res_data = head_dat[DATA_W-1:0];
    end

    // Sticky error next-state: a new event wins over a clear on the same edge.
    always_comb begin
        overflow_d  = fifo_drop  || (overflow_q  && !Err_clr);
        collision_d = multi_flag || (collision_q && !Err_clr);
    end

    // Sticky error registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            collision_q <= collision_d;
        end
    end

    assign Overflow_err  = overflow_q;
    assign Collision_err = collision_q;

endmodule
